// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit-side types
package uart_pkg;
  typedef enum logic [1:0] {
    TX_SPACE  = 2'b00,
    TX_MARK   = 2'b01,
    TX_DATA   = 2'b10,
    TX_PARITY = 2'b11
  } tx_out_sel_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} tx_state_t;
endpackage

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: frame sequencing FSM driving the UART TX datapath strobes
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter bit SYNC_START = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_tick,
  input  logic       tx_queue_empty,
  input  logic       tx_bits_cnt_top,
  input  logic       parity_en,
  input  logic       double_stop_bits,
  output logic       tx_queue_re,
  output logic       tx_shift_reg_we,
  output logic       tx_shift_reg_se,
  output logic       tx_bits_cnt_en,
  output logic       tx_bits_cnt_reset,
  output logic       tx_parity_we,
  output logic       tx_parity_reset,
  output logic [1:0] tx_out_sel,
  output logic       busy,
  output logic       tx_done
);
  tx_state_t state, state_nxt;
  logic cfg_parity, cfg_dstop, frame_end, load, data_tick;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cfg_parity <= 1'b0;
      cfg_dstop  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cfg_parity <= parity_en;
        cfg_dstop  <= double_stop_bits;
      end
    end
  end
  always_comb begin
    frame_end = !reset && bit_tick && (state == STOP2 || (state == STOP1 && !cfg_dstop));
    load = !reset && !tx_queue_empty && (state == IDLE ? (bit_tick || !SYNC_START) : frame_end);
    data_tick = !reset && bit_tick && state == DATA;
    tx_queue_re = load;
    tx_shift_reg_we = load;
    tx_shift_reg_se = data_tick;
    tx_bits_cnt_en = data_tick;
    tx_parity_we = data_tick;
    tx_bits_cnt_reset = reset || load;
    tx_parity_reset = reset || load;
    tx_done = frame_end;
    busy = !reset && state != IDLE;
    tx_out_sel = reset ? TX_MARK :
                 state == START  ? TX_SPACE :
                 state == DATA   ? TX_DATA :
                 state == PARITY ? TX_PARITY : TX_MARK;
    state_nxt = load ? START :
                frame_end ? IDLE :
                !bit_tick ? state :
                state == START ? DATA :
                state == DATA ? (tx_bits_cnt_top ? (cfg_parity ? PARITY : STOP1) : DATA) :
                state == PARITY ? STOP1 :
                state == STOP1 ? STOP2 : state;
  end
endmodule
